fetch_unit: RTL



---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_unit_pc_reg.sv | 41 ++++
 rtl/fetch_unit.sv | 82 ++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
package fetch_pkg;

    localparam int INSTR_W = 8;

    typedef enum logic {RUN, HALTED} fetch_state_t;

    // Wraps at the memory depth rather than at 2**PC_W, so non-power-of-two depths work.
    function automatic int unsigned next_pc(input int unsigned pc, input int unsigned depth);
        return (pc == depth - 1) ? 0 : pc + 1;
    endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter: redirect with out-of-range clamp, increment-with-wrap, hold.
module pc_reg
    import fetch_pkg::*;
#(
    parameter  int IMEM_DEPTH = 4,
    parameter  int RESET_PC   = 0,
    localparam int PC_W       = $clog2(IMEM_DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [PC_W-1:0] target,
    input  logic            incr,
    output logic [PC_W-1:0] pc,
    output logic            bad_target
);

    logic target_oob;

    assign target_oob = (32'(target) >= 32'(IMEM_DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= PC_W'(RESET_PC);
            bad_target <= 1'b0;
        end else begin
            bad_target <= 1'b0;
            if (load) begin
                if (target_oob) begin
                    pc         <= '0;
                    bad_target <= 1'b1;
                end else begin
                    pc <= target;
                end
            end else if (incr) begin
                pc <= PC_W'(next_pc(32'(pc), IMEM_DEPTH));
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, captures instruction memory output into the IR and
// hands it to the decoder over valid/ready, with branch redirect and halt/resume.
//
// state  | meaning
// RUN    | fetching whenever the IR is free or being consumed
// HALTED | no fetch, PC frozen; a held IR can still drain
module fetch_unit
    import fetch_pkg::*;
#(
    parameter  int IMEM_DEPTH = 4,
    parameter  int RESET_PC   = 0,
    localparam int PC_W       = $clog2(IMEM_DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PC_W-1:0]    pc_value,
    input  logic [INSTR_W-1:0] instruction,
    output logic [INSTR_W-1:0] ir_out,
    output logic [PC_W-1:0]    ir_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               halt,
    input  logic               resume,
    output logic               halted,
    output logic               bad_target
);

    fetch_state_t state;
    logic         handshake;
    logic         loadable;
    logic         fetch_en;

    assign handshake = ir_valid && ir_ready;
    assign loadable  = !ir_valid || handshake;
    assign fetch_en  = (state == RUN) && !branch_taken && !halt && loadable;
    assign halted    = (state == HALTED);

    pc_reg #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .RESET_PC   (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .reset      (reset),
        .load       (branch_taken),
        .target     (branch_target),
        .incr       (fetch_en),
        .pc         (pc_value),
        .bad_target (bad_target)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            ir_out   <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (branch_taken) begin
                        ir_valid <= 1'b0;
                    end else if (halt) begin
                        state <= HALTED;
                        if (handshake) ir_valid <= 1'b0;
                    end else if (loadable) begin
                        ir_out   <= instruction;
                        ir_pc    <= pc_value;
                        ir_valid <= 1'b1;
                    end
                end
                HALTED: begin
                    if (branch_taken || handshake) ir_valid <= 1'b0;
                    if (resume) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule
